// File: rtl/ochiba_pkg.sv
// Shared encodings for the memory-access stage: funct3 access sizes,
// writeback/branch control encodings, FSM states and the MEM/WB record.
package ochiba_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_CSR = 2'b11;

  localparam logic [1:0] BRC_NONE = 2'b00;
  localparam logic [1:0] BRC_BEQ  = 2'b01;
  localparam logic [1:0] BRC_BNE  = 2'b10;
  localparam logic [1:0] BRC_JUMP = 2'b11;

  localparam logic [1:0] PCS_SEQ = 2'b00;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] aluresult;
    logic [31:0] branchimm;
    logic [31:0] pc;
    logic [1:0]  mem2reg;
    logic [1:0]  pcsource;
    logic [1:0]  branchcntl;
    logic        regwrite;
    logic        zero;
    logic [31:0] dmemdata;
    logic [31:0] csrrdata;
  } regm_t;

  // Anything that is not an explicit byte or half access is a word access.
  function automatic access_size_e decode_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte-enables and replicated write data,
// load extraction with sign/zero extension, and the misalignment flag.
module load_store_align
  import ochiba_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] raw_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  access_size_e size;
  logic         is_unsigned;
  logic [7:0]   sel_byte;
  logic [15:0]  sel_half;

  always_comb begin
    size        = decode_size(funct3);
    is_unsigned = funct3[2];

    case (addr_lo)
      2'd0:    sel_byte = raw_data[7:0];
      2'd1:    sel_byte = raw_data[15:8];
      2'd2:    sel_byte = raw_data[23:16];
      default: sel_byte = raw_data[31:24];
    endcase
    sel_half = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];

    be         = 4'b1111;
    wdata      = store_data;
    load_data  = raw_data;
    misaligned = 1'b0;

    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        load_data  = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage with MEM/WB register and single-outstanding
// data-memory bus. Define MEM_TIMEOUT_EN to add the ack-wait timeout (bus_timeout).
module mem_access_stage
  import ochiba_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       REGErd,
  input  logic [WIDTH-1:0] REGEaluresult,
  input  logic [WIDTH-1:0] REGEbranchimm,
  input  logic [WIDTH-1:0] REGEpc,
  input  logic [WIDTH-1:0] REGEcsrrdata,
  input  logic [WIDTH-1:0] REGEstoredata,
  input  logic [1:0]       REGEmem2reg,
  input  logic [1:0]       REGEpcsource,
  input  logic [1:0]       REGEbranchcntl,
  input  logic             REGEregwrite,
  input  logic             REGEzero,
  input  logic             REGEmemread,
  input  logic             REGEmemwrite,
  input  logic [2:0]       REGEfunct3,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             mem_stall,
`ifdef MEM_TIMEOUT_EN
  output logic             bus_timeout,
`endif
  output logic             misalign,
  output logic [4:0]       REGMrd,
  output logic [WIDTH-1:0] REGMaluresult,
  output logic [WIDTH-1:0] REGMbranchimm,
  output logic [WIDTH-1:0] REGMpc,
  output logic [1:0]       REGMmem2reg,
  output logic [1:0]       REGMpcsource,
  output logic [1:0]       REGMbranchcntl,
  output logic             REGMregwrite,
  output logic             REGMzero,
  output logic [WIDTH-1:0] REGMdmemdata,
  output logic [WIDTH-1:0] REGMcsrrdata
);

  mem_state_e  state_q, state_d;
  regm_t       regm_q, regm_d;
  regm_t       regm_capture, regm_done, regm_bubble;

  logic        mem_op, is_load, is_store;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_fmt;
  logic        misaligned;
  logic        req_c, stall_c, misalign_c;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_c;
`endif

  assign mem_op   = REGEmemread | REGEmemwrite;
  assign is_load  = REGEmemread;
  assign is_store = REGEmemwrite & ~REGEmemread;

  load_store_align u_align (
    .funct3     (REGEfunct3),
    .addr_lo    (REGEaluresult[1:0]),
    .store_data (REGEstoredata),
    .raw_data   (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_fmt),
    .misaligned (misaligned)
  );

  // Candidate MEM/WB records: plain capture, completed access, and a bubble
  // that keeps the data fields but kills every architectural side effect.
  always_comb begin
    regm_capture            = regm_q;
    regm_capture.rd         = REGErd;
    regm_capture.aluresult  = REGEaluresult;
    regm_capture.branchimm  = REGEbranchimm;
    regm_capture.pc         = REGEpc;
    regm_capture.mem2reg    = REGEmem2reg;
    regm_capture.pcsource   = REGEpcsource;
    regm_capture.branchcntl = REGEbranchcntl;
    regm_capture.regwrite   = REGEregwrite;
    regm_capture.zero       = REGEzero;
    regm_capture.csrrdata   = REGEcsrrdata;
    regm_capture.dmemdata   = '0;

    regm_done          = regm_capture;
    regm_done.dmemdata = is_load ? load_fmt : '0;

    regm_bubble            = regm_q;
    regm_bubble.regwrite   = 1'b0;
    regm_bubble.branchcntl = BRC_NONE;
    regm_bubble.pcsource   = PCS_SEQ;
  end

  always_comb begin
    state_d    = state_q;
    regm_d     = regm_q;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_c  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!mem_op) begin
          regm_d = regm_capture;
        end else if (misaligned) begin
          misalign_c = 1'b1;
          regm_d     = regm_bubble;
        end else begin
          req_c = 1'b1;
          if (dmem_ack) begin
            regm_d = regm_done;
          end else begin
            stall_c = 1'b1;
            regm_d  = regm_bubble;
            state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = CNT_W'(1);
`endif
          end
        end
      end

      // Upstream is frozen by mem_stall, so the REGE* fields still describe the access.
      ST_WAIT: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          regm_d  = regm_done;
          state_d = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q >= TIMEOUT_VAL) begin
          req_c     = 1'b0;
          timeout_c = 1'b1;
          regm_d    = regm_bubble;
          state_d   = ST_IDLE;
`endif
        end else begin
          stall_c = 1'b1;
          regm_d  = regm_bubble;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      regm_q  <= '0;
    end else begin
      state_q <= state_d;
      regm_q  <= regm_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_timeout = timeout_c & rst_n;
`endif

  // Bus strobes are gated by reset so a held-in-reset stage never issues a request.
  assign dmem_req   = req_c & rst_n;
  assign dmem_we    = req_c & rst_n & is_store;
  assign dmem_be    = (req_c & rst_n) ? lane_be : 4'b0000;
  assign dmem_addr  = {REGEaluresult[WIDTH-1:2], 2'b00};
  assign dmem_wdata = lane_wdata;
  assign mem_stall  = stall_c & rst_n;
  assign misalign   = misalign_c & rst_n;

  assign REGMrd         = regm_q.rd;
  assign REGMaluresult  = regm_q.aluresult;
  assign REGMbranchimm  = regm_q.branchimm;
  assign REGMpc         = regm_q.pc;
  assign REGMmem2reg    = regm_q.mem2reg;
  assign REGMpcsource   = regm_q.pcsource;
  assign REGMbranchcntl = regm_q.branchcntl;
  assign REGMregwrite   = regm_q.regwrite;
  assign REGMzero       = regm_q.zero;
  assign REGMdmemdata   = regm_q.dmemdata;
  assign REGMcsrrdata   = regm_q.csrrdata;

endmodule
